uart_serial_port: RTL and testbench

// - Parametrised UART port: baud tick generator, 16x-oversampled receiver, transmitter and RX FIFO.
// - Sits between the RS232/HC-06 pins and user logic; all configuration is by parameter.
// - Generalises the fixed 8N1 link:
//   - configurable data width, parity and stop bits
//   - start-bit glitch rejection
//   - parity and framing error flags
//   - buffered RX with valid/ready handshakes on both directions.

---
 rtl/uart_serial_port.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_serial_port.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_serial_port.sv
// uart_serial_port: parametrised UART with baud tick, 16x RX, TX and RX FIFO.
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
module uart_serial_port #(
    parameter int BAUD_DIV   = 325,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          Rx,
    output logic                          Tx,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          rx_overflow,
    input  logic                          rx_ovf_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_BITS + 2;
    localparam logic [15:0] BAUD_MAX   = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  DBITS_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  SBITS_LAST = 4'(STOP_BITS - 1);
    localparam logic        PAR_ON     = (PARITY_EN != 0);
    localparam logic        PAR_ODD    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    logic [15:0] baud_cnt;
    logic        tick;

    assign tick = (baud_cnt == BAUD_MAX);

    // Free-running baud divider, one tick per BAUD_DIV cycles
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)    baud_cnt <= '0;
        else if (tick) baud_cnt <= '0;
        else           baud_cnt <= baud_cnt + 16'd1;
    end

    logic rx_meta, rx_sync;

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
        end
    end

    state_t               rx_state, rx_next;
    logic [3:0]           rx_tcnt, rx_bcnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par, rx_ferr_acc, rx_push, rx_done;
    logic                 rx_bit_end, rx_perr_calc;

    assign rx_bit_end   = tick && (rx_tcnt == 4'd15);
    assign rx_perr_calc = PAR_ON && ((^rx_shift ^ rx_par) != PAR_ODD);

    // RX state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) rx_state <= S_IDLE;
        else        rx_state <= rx_next;
    end

    // RX next state: mid-start check, then one sample per 16 ticks
    always_comb begin
        rx_next = rx_state;
        rx_done = 1'b0;
        unique case (rx_state)
            S_IDLE:
                if (tick && !rx_sync) rx_next = S_START;
            S_START:
                if (tick && rx_tcnt == 4'd7)
                    rx_next = rx_sync ? S_IDLE : S_DATA;
            S_DATA:
                if (rx_bit_end && rx_bcnt == DBITS_LAST)
                    rx_next = PAR_ON ? S_PARITY : S_STOP;
            S_PARITY:
                if (rx_bit_end) rx_next = S_STOP;
            S_STOP:
                if (rx_bit_end && rx_bcnt == SBITS_LAST) begin
                    rx_next = S_IDLE;
                    rx_done = 1'b1;
                end
            default: rx_next = S_IDLE;
        endcase
    end

    // RX datapath: tick/bit counters, data shifter, parity and stop capture
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_tcnt     <= '0;
            rx_bcnt     <= '0;
            rx_shift    <= '0;
            rx_par      <= 1'b0;
            rx_ferr_acc <= 1'b0;
            rx_push     <= 1'b0;
        end else begin
            rx_push <= rx_done;
            if (rx_state != rx_next || rx_state == S_IDLE) rx_tcnt <= '0;
            else if (tick)                                 rx_tcnt <= rx_tcnt + 4'd1;
            if (rx_state != rx_next) rx_bcnt <= '0;
            else if (rx_bit_end)     rx_bcnt <= rx_bcnt + 4'd1;
            if (rx_state == S_DATA && rx_bit_end)
                rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_state == S_PARITY && rx_bit_end)
                rx_par <= rx_sync;
            if (rx_state == S_START)
                rx_ferr_acc <= 1'b0;
            else if (rx_state == S_STOP && rx_bit_end && !rx_sync)
                rx_ferr_acc <= 1'b1;
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, wr_en;
    logic [EW-1:0] head;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign rx_valid = (count != '0);
    assign pop      = rx_valid && rx_ready;
    assign wr_en    = rx_push && (!full || pop);
    assign head     = mem[rd_ptr];
    assign rx_data  = rx_valid ? head[DATA_BITS-1:0] : '0;
    assign rx_perr  = rx_valid ? head[DATA_BITS]     : 1'b0;
    assign rx_ferr  = rx_valid ? head[DATA_BITS+1]   : 1'b0;
    assign rx_count = count;

    // FIFO storage, written with {ferr, perr, data}
    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_ptr] <= {rx_ferr_acc, rx_perr_calc, rx_shift};
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      count <= count + CW'(1);
            else if (!wr_en && pop) count <= count - CW'(1);
            if (rx_push && full && !pop) rx_overflow <= 1'b1;
            else if (rx_ovf_clr)         rx_overflow <= 1'b0;
        end
    end

    state_t               tx_state, tx_next;
    logic [3:0]           tx_tcnt, tx_bcnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par, tx_line, tx_bit_end;

    assign tx_bit_end = tick && (tx_tcnt == 4'd15);
    assign tx_ready   = (tx_state == S_IDLE);
    assign Tx         = tx_line;

    // TX state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) tx_state <= S_IDLE;
        else        tx_state <= tx_next;
    end

    // TX next state and line level, each bit held for 16 ticks
    always_comb begin
        tx_next = tx_state;
        tx_line = 1'b1;
        unique case (tx_state)
            S_IDLE:
                if (tx_valid) tx_next = S_START;
            S_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) tx_next = S_DATA;
            end
            S_DATA: begin
                tx_line = tx_shift[0];
                if (tx_bit_end && tx_bcnt == DBITS_LAST)
                    tx_next = PAR_ON ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                tx_line = tx_par;
                if (tx_bit_end) tx_next = S_STOP;
            end
            S_STOP:
                if (tx_bit_end && tx_bcnt == SBITS_LAST) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    // TX datapath: latch on handshake, shift one data bit per bit time
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            if (tx_state != tx_next) tx_tcnt <= '0;
            else if (tick)           tx_tcnt <= tx_tcnt + 4'd1;
            if (tx_state != tx_next) tx_bcnt <= '0;
            else if (tx_bit_end)     tx_bcnt <= tx_bcnt + 4'd1;
            if (tx_state == S_IDLE && tx_valid) begin
                tx_shift <= tx_data;
                tx_par   <= ^tx_data ^ PAR_ODD;
            end else if (tx_state == S_DATA && tx_bit_end) begin
                tx_shift <= tx_shift >> 1;
            end
        end
    end
endmodule

// File: tb/tb_uart_serial_port.sv
// tb_uart_serial_port: directed bench for uart_serial_port.
// dut_a is 8N1 depth 16; dut_b is odd parity, 2 stop bits, depth 4.
module tb_uart_serial_port;
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;

    logic       rxa = 1'b1, txa;
    logic [7:0] txa_data = 8'h00;
    logic       txa_valid = 1'b0, txa_ready;
    logic [7:0] rxa_data;
    logic       rxa_perr, rxa_ferr, rxa_valid;
    logic       rxa_rdy = 1'b0;
    logic [4:0] rxa_count;
    logic       rxa_ovf, rxa_clr = 1'b0;

    logic       rxb, rxb_drv = 1'b1, loop_en = 1'b0, txb;
    logic [7:0] txb_data = 8'h00;
    logic       txb_valid = 1'b0, txb_ready;
    logic [7:0] rxb_data;
    logic       rxb_perr, rxb_ferr, rxb_valid;
    logic       rdy_b = 1'b0, pop_on_push = 1'b0, rxb_ready;
    logic [2:0] rxb_count;
    logic       rxb_ovf, rxb_clr = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    assign rxb       = loop_en ? txb : rxb_drv;
    assign rxb_ready = rdy_b | (pop_on_push & dut_b.rx_push);

    always #5 Clk = ~Clk;

    uart_serial_port #(.BAUD_DIV(4)) dut_a (
        .Clk(Clk), .Rst_n(Rst_n), .Rx(rxa), .Tx(txa),
        .tx_data(txa_data), .tx_valid(txa_valid), .tx_ready(txa_ready),
        .rx_data(rxa_data), .rx_perr(rxa_perr), .rx_ferr(rxa_ferr),
        .rx_valid(rxa_valid), .rx_ready(rxa_rdy), .rx_count(rxa_count),
        .rx_overflow(rxa_ovf), .rx_ovf_clr(rxa_clr)
    );

    uart_serial_port #(
        .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1),
        .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .Clk(Clk), .Rst_n(Rst_n), .Rx(rxb), .Tx(txb),
        .tx_data(txb_data), .tx_valid(txb_valid), .tx_ready(txb_ready),
        .rx_data(rxb_data), .rx_perr(rxb_perr), .rx_ferr(rxb_ferr),
        .rx_valid(rxb_valid), .rx_ready(rxb_ready), .rx_count(rxb_count),
        .rx_overflow(rxb_ovf), .rx_ovf_clr(rxb_clr)
    );

    function automatic logic odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    task automatic wait_idle_b();
        int c = 0;
        while (!txb_ready && c < 2000) begin
            @(negedge Clk);
            c++;
        end
        n_checks++;
        if (!txb_ready) begin
            n_fail++;
            $display("FAIL tx_idle_timeout got ready=%0b want 1", txb_ready);
        end
    endtask

    task automatic send_b(input logic [7:0] d);
        wait_idle_b();
        @(negedge Clk);
        txb_data  = d;
        txb_valid = 1'b1;
        @(negedge Clk);
        txb_valid = 1'b0;
    endtask

    task automatic pop_b();
        @(negedge Clk);
        rdy_b = 1'b1;
        @(negedge Clk);
        rdy_b = 1'b0;
    endtask

    task automatic inject(input logic [7:0] d, input logic p,
                          input logic s1, input logic s2);
        logic [11:0] fr;
        fr = {s2, s1, p, d, 1'b0};
        @(negedge Clk);
        for (int b = 0; b < 12; b++) begin
            rxb_drv = fr[b];
            repeat (64) @(negedge Clk);
        end
        rxb_drv = 1'b1;
        repeat (64) @(negedge Clk);
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if ({txa, txa_ready, rxa_valid, rxa_count, rxa_ovf} !== 9'b11_0_00000_0) begin
            n_fail++;
            $display("FAIL reset_a got %b want 110000000",
                     {txa, txa_ready, rxa_valid, rxa_count, rxa_ovf});
        end
        n_checks++;
        if ({txb, txb_ready, rxb_valid, rxb_count, rxb_ovf} !== 7'b11_0_000_0) begin
            n_fail++;
            $display("FAIL reset_b got %b want 1100000",
                     {txb, txb_ready, rxb_valid, rxb_count, rxb_ovf});
        end
        n_checks++;
        if ({rxb_ferr, rxb_perr, rxb_data} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_head got %h want 000",
                     {rxb_ferr, rxb_perr, rxb_data});
        end
        Rst_n = 1'b1;
        repeat (5) @(negedge Clk);
    endtask

    task automatic test_tx_8n1();
        logic        wave [700];
        logic        rdy  [700];
        logic [8:0]  fr;
        int          s;
        fr = {1'b1, 8'hA5};
        @(negedge Clk);
        n_checks++;
        if (txa_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_ready_idle got %b want 1", txa_ready);
        end
        txa_data  = 8'hA5;
        txa_valid = 1'b1;
        for (int i = 0; i < 700; i++) begin
            @(negedge Clk);
            if (i == 0)   txa_valid = 1'b0;
            if (i == 100) begin
                txa_data  = 8'h00;
                txa_valid = 1'b1;
            end
            if (i == 110) txa_valid = 1'b0;
            wave[i] = txa;
            rdy[i]  = txa_ready;
        end
        n_checks++;
        if (wave[0] !== 1'b0 || rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_start_edge got tx=%b rdy=%b want 0 0", wave[0], rdy[0]);
        end
        s = 0;
        while (s < 100 && wave[s] === 1'b0) s++;
        n_checks++;
        if (s < 61 || s > 64) begin
            n_fail++;
            $display("FAIL tx_start_len got %0d want 61..64", s);
            s = 64;
        end
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (wave[s+64*k] !== fr[k] || wave[s+64*k+63] !== fr[k]) begin
                n_fail++;
                $display("FAIL tx_bit%0d got %b..%b want %b", k,
                         wave[s+64*k], wave[s+64*k+63], fr[k]);
            end
        end
        n_checks++;
        if (rdy[s+575] !== 1'b0 || rdy[s+576] !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_ready_return got %b%b want 01", rdy[s+575], rdy[s+576]);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] exp [3];
        exp[0] = 8'h3C;
        exp[1] = 8'hFF;
        exp[2] = 8'h00;
        loop_en = 1'b1;
        for (int i = 0; i < 3; i++) send_b(exp[i]);
        wait_idle_b();
        repeat (20) @(negedge Clk);
        n_checks++;
        if (rxb_count !== 3'd3) begin
            n_fail++;
            $display("FAIL loop_count got %0d want 3", rxb_count);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_checks++;
            if ({rxb_valid, rxb_ferr, rxb_perr, rxb_data} !== {3'b100, exp[i]}) begin
                n_fail++;
                $display("FAIL loop_entry%0d got %h want %h", i,
                         {rxb_valid, rxb_ferr, rxb_perr, rxb_data}, {3'b100, exp[i]});
            end
            pop_b();
        end
        n_checks++;
        if (rxb_count !== 3'd0) begin
            n_fail++;
            $display("FAIL loop_drain got %0d want 0", rxb_count);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_error_frames();
        inject(8'h55, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({rxb_count, rxb_ferr, rxb_perr, rxb_data} !== {3'd1, 2'b01, 8'h55}) begin
            n_fail++;
            $display("FAIL perr_frame got %h want %h",
                     {rxb_count, rxb_ferr, rxb_perr, rxb_data}, {3'd1, 2'b01, 8'h55});
        end
        pop_b();
        inject(8'h0F, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({rxb_count, rxb_ferr, rxb_perr, rxb_data} !== {3'd1, 2'b10, 8'h0F}) begin
            n_fail++;
            $display("FAIL ferr_frame got %h want %h",
                     {rxb_count, rxb_ferr, rxb_perr, rxb_data}, {3'd1, 2'b10, 8'h0F});
        end
        pop_b();
        @(negedge Clk);
        rxb_drv = 1'b0;
        repeat (20) @(negedge Clk);
        rxb_drv = 1'b1;
        repeat (300) @(negedge Clk);
        n_checks++;
        if (rxb_count !== 3'd0 || rxb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch got count=%0d valid=%b want 0 0", rxb_count, rxb_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        rdy_b = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i * 8'h11);
            inject(d, odd_par(d), 1'b1, 1'b1);
        end
        n_checks++;
        if ({rxb_count, rxb_ovf} !== {3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_state got count=%0d ovf=%b want 4 1", rxb_count, rxb_ovf);
        end
        n_checks++;
        if ({rxb_ferr, rxb_perr, rxb_data} !== {2'b00, 8'h11}) begin
            n_fail++;
            $display("FAIL ovf_head got %h want 011", {rxb_ferr, rxb_perr, rxb_data});
        end
        @(negedge Clk);
        rxb_clr = 1'b1;
        @(negedge Clk);
        rxb_clr = 1'b0;
        n_checks++;
        if (rxb_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got %b want 0", rxb_ovf);
        end
    endtask

    task automatic test_full_pop_push();
        logic [7:0] exp [4];
        exp[0] = 8'h22;
        exp[1] = 8'h33;
        exp[2] = 8'h44;
        exp[3] = 8'h66;
        pop_on_push = 1'b1;
        inject(8'h66, odd_par(8'h66), 1'b1, 1'b1);
        pop_on_push = 1'b0;
        n_checks++;
        if ({rxb_count, rxb_ovf} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL full_poppush got count=%0d ovf=%b want 4 0", rxb_count, rxb_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            n_checks++;
            if ({rxb_valid, rxb_ferr, rxb_perr, rxb_data} !== {3'b100, exp[i]}) begin
                n_fail++;
                $display("FAIL full_entry%0d got %h want %h", i,
                         {rxb_valid, rxb_ferr, rxb_perr, rxb_data}, {3'b100, exp[i]});
            end
            pop_b();
        end
    endtask

    task automatic test_reset_mid();
        loop_en = 1'b1;
        send_b(8'h81);
        wait_idle_b();
        repeat (10) @(negedge Clk);
        n_checks++;
        if (rxb_count !== 3'd1) begin
            n_fail++;
            $display("FAIL rst_pre_count got %0d want 1", rxb_count);
        end
        send_b(8'hC3);
        repeat (287) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        n_checks++;
        if ({txb, txb_ready, txa, rxb_count, rxb_valid} !== {3'b111, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid got %b want 1110000",
                     {txb, txb_ready, txa, rxb_count, rxb_valid});
        end
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (5) @(negedge Clk);
        send_b(8'h5A);
        wait_idle_b();
        repeat (10) @(negedge Clk);
        n_checks++;
        if ({rxb_count, rxb_ferr, rxb_perr, rxb_data} !== {3'd1, 2'b00, 8'h5A}) begin
            n_fail++;
            $display("FAIL rst_after got %h want %h",
                     {rxb_count, rxb_ferr, rxb_perr, rxb_data}, {3'd1, 2'b00, 8'h5A});
        end
        pop_b();
        loop_en = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tx_8n1();
        test_loopback();
        test_error_frames();
        test_overflow();
        test_full_pop_push();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
